// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the three-port SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_TURN
  } state_t;

  typedef enum logic [1:0] {
    REQ_WR,
    REQ_RD0,
    REQ_RD1
  } req_idx_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection: the write port always wins; between the two
// read ports the pointer decides when both are pending.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic     wr_req,
  input  logic     rd0_req,
  input  logic     rd1_req,
  input  logic     rr_ptr,
  output req_idx_t winner
);

  always_comb begin
    winner = REQ_RD0;
    if (wr_req)
      winner = REQ_WR;
    else if (rd0_req && rd1_req)
      winner = rr_ptr ? REQ_RD1 : REQ_RD0;
    else if (rd1_req)
      winner = REQ_RD1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-SRAM arbiter for one writer and two readers (IDLE -> ACCESS -> TURN).
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin between the read ports.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_CYC = 2
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd0_req,
  input  logic [ADDR_W-1:0] i_rd0_addr,
  output logic              o_rd0_valid,
  output logic [DATA_W-1:0] o_rd0_data,
  input  logic              i_rd1_req,
  input  logic [ADDR_W-1:0] i_rd1_addr,
  output logic              o_rd1_valid,
  output logic [DATA_W-1:0] o_rd1_data,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  output logic [DATA_W-1:0] o_SRAM_DQ_OUT,
  output logic              o_SRAM_DQ_OE,
  input  logic [DATA_W-1:0] i_SRAM_DQ_IN,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_busy
);

  // ACC_CYC must lie in 1..15 to fit the strobe counter.
  localparam logic [3:0] ACC_LOAD = ACC_CYC[3:0];

  state_t   state;
  logic [3:0] cnt;
  req_idx_t owner;
  req_idx_t winner;
  logic     any_req;
  logic     rr_ptr;

  assign any_req = i_wr_req | i_rd0_req | i_rd1_req;
  assign o_busy  = (state != S_IDLE);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Pointer names the read port that wins the next read-read tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      rr_ptr <= 1'b0;
    else if (state == S_IDLE && any_req && winner != REQ_WR)
      rr_ptr <= (winner == REQ_RD0);
  end
`else
  assign rr_ptr = 1'b0;
`endif

  sram_arb_pick u_pick (
    .wr_req  (i_wr_req),
    .rd0_req (i_rd0_req),
    .rd1_req (i_rd1_req),
    .rr_ptr  (rr_ptr),
    .winner  (winner)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      owner         <= REQ_RD0;
      o_wr_ack      <= 1'b0;
      o_rd0_valid   <= 1'b0;
      o_rd1_valid   <= 1'b0;
      o_rd0_data    <= '0;
      o_rd1_data    <= '0;
      o_SRAM_ADDR   <= '0;
      o_SRAM_DQ_OUT <= '0;
      o_SRAM_DQ_OE  <= 1'b0;
      o_SRAM_WE_N   <= 1'b1;
      o_SRAM_OE_N   <= 1'b1;
      o_SRAM_CE_N   <= 1'b1;
    end else begin
      o_wr_ack    <= 1'b0;
      o_rd0_valid <= 1'b0;
      o_rd1_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state       <= S_ACCESS;
            cnt         <= ACC_LOAD;
            owner       <= winner;
            o_SRAM_CE_N <= 1'b0;
            case (winner)
              REQ_WR: begin
                o_SRAM_ADDR   <= i_wr_addr;
                o_SRAM_DQ_OUT <= i_wr_data;
                o_SRAM_WE_N   <= 1'b0;
                o_SRAM_DQ_OE  <= 1'b1;
              end
              REQ_RD0: begin
                o_SRAM_ADDR <= i_rd0_addr;
                o_SRAM_OE_N <= 1'b0;
              end
              REQ_RD1: begin
                o_SRAM_ADDR <= i_rd1_addr;
                o_SRAM_OE_N <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_ACCESS: begin
          // Last strobe cycle: sample read data and raise the done pulse.
          if (cnt == 4'd1) begin
            state       <= S_TURN;
            cnt         <= 4'd0;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            case (owner)
              REQ_WR:  o_wr_ack <= 1'b1;
              REQ_RD0: begin
                o_rd0_valid <= 1'b1;
                o_rd0_data  <= i_SRAM_DQ_IN;
              end
              REQ_RD1: begin
                o_rd1_valid <= 1'b1;
                o_rd1_data  <= i_SRAM_DQ_IN;
              end
              default: ;
            endcase
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_TURN: begin
          // Write data stays driven through this cycle as hold time after WE_N.
          state        <= S_IDLE;
          o_SRAM_CE_N  <= 1'b1;
          o_SRAM_DQ_OE <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, corner-case sequences,
// and a randomized run against a transaction-level reference model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int ACC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_req = 0, rd0_req = 0, rd1_req = 0;
  logic [AW-1:0] wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, rd0_valid, rd1_valid;
  logic [DW-1:0] rd0_data, rd1_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] dq_out, dq_in;
  logic          dq_oe, we_n, oe_n, ce_n, busy;

  logic          b_rd1_req = 0;
  logic [AW-1:0] b_rd1_addr = '0;
  logic          b_wr_ack, b_rd0_valid, b_rd1_valid;
  logic [DW-1:0] b_rd0_data, b_rd1_data, b_dq_out, b_dq_in;
  logic [AW-1:0] b_addr;
  logic          b_dq_oe, b_we_n, b_oe_n, b_ce_n, b_busy;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(ACC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd0_req(rd0_req), .i_rd0_addr(rd0_addr), .o_rd0_valid(rd0_valid), .o_rd0_data(rd0_data),
    .i_rd1_req(rd1_req), .i_rd1_addr(rd1_addr), .o_rd1_valid(rd1_valid), .o_rd1_data(rd1_data),
    .o_SRAM_ADDR(sram_addr), .o_SRAM_DQ_OUT(dq_out), .o_SRAM_DQ_OE(dq_oe), .i_SRAM_DQ_IN(dq_in),
    .o_SRAM_WE_N(we_n), .o_SRAM_OE_N(oe_n), .o_SRAM_CE_N(ce_n), .o_busy(busy)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(1)) dut_fast (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(1'b0), .i_wr_addr('0), .i_wr_data('0), .o_wr_ack(b_wr_ack),
    .i_rd0_req(1'b0), .i_rd0_addr('0), .o_rd0_valid(b_rd0_valid), .o_rd0_data(b_rd0_data),
    .i_rd1_req(b_rd1_req), .i_rd1_addr(b_rd1_addr), .o_rd1_valid(b_rd1_valid), .o_rd1_data(b_rd1_data),
    .o_SRAM_ADDR(b_addr), .o_SRAM_DQ_OUT(b_dq_out), .o_SRAM_DQ_OE(b_dq_oe), .i_SRAM_DQ_IN(b_dq_in),
    .o_SRAM_WE_N(b_we_n), .o_SRAM_OE_N(b_oe_n), .o_SRAM_CE_N(b_ce_n), .o_busy(b_busy)
  );

  // Behavioural SRAM: unwritten words return an address-derived pattern.
  function automatic logic [15:0] dflt(input logic [7:0] a);
    return {a, ~a} ^ 16'h3C3C;
  endfunction

  logic [15:0]  sram_mem [0:255];
  logic [255:0] written = '0;

  assign dq_in = (!ce_n && !oe_n) ?
                 (written[sram_addr[7:0]] ? sram_mem[sram_addr[7:0]] : dflt(sram_addr[7:0])) : '0;

  always @(posedge clk) begin
    if (!ce_n && !we_n && dq_oe) begin
      sram_mem[sram_addr[7:0]] <= dq_out;
      written[sram_addr[7:0]]  <= 1'b1;
    end
  end

  assign b_dq_in = (!b_ce_n && !b_oe_n) ? (b_addr[15:0] ^ 16'h5A5A) : '0;

  int checks = 0;
  int passes = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input bit w, input bit r0, input bit r1,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req = w;  rd0_req = r0; rd1_req = r1;
    wr_addr = a; rd0_addr = a; rd1_addr = a;
    wr_data = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, '0, '0);
    #1;
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_ce_n", 32'(ce_n), 1);
    check_output("rst_we_n", 32'(we_n), 1);
    check_output("rst_oe_n", 32'(oe_n), 1);
    check_output("rst_dq_oe", 32'(dq_oe), 0);
    check_output("rst_addr", 32'(sram_addr), 0);
    check_output("rst_pulses", 32'({wr_ack, rd0_valid, rd1_valid}), 0);
    check_output("rst_rd_data", 32'({rd0_data, rd1_data}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Observe n cycles, logging strobe counts and every done pulse.
  req_idx_t    ev_who[$];
  int          ev_at[$];
  logic [15:0] ev_data[$];
  int          we_cnt, oe_cnt, dqoe_cnt;

  task automatic watch(input int n, input bit keep);
    we_cnt = 0; oe_cnt = 0; dqoe_cnt = 0;
    ev_who.delete(); ev_at.delete(); ev_data.delete();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (!we_n)  we_cnt++;
      if (!oe_n)  oe_cnt++;
      if (dq_oe)  dqoe_cnt++;
      if (wr_ack) begin
        ev_who.push_back(REQ_WR); ev_at.push_back(i); ev_data.push_back('0);
        if (!keep) wr_req = 0;
      end
      if (rd0_valid) begin
        ev_who.push_back(REQ_RD0); ev_at.push_back(i); ev_data.push_back(rd0_data);
        if (!keep) rd0_req = 0;
      end
      if (rd1_valid) begin
        ev_who.push_back(REQ_RD1); ev_at.push_back(i); ev_data.push_back(rd1_data);
        if (!keep) rd1_req = 0;
      end
    end
  endtask

  function automatic int at_of(input int i);
    return (ev_at.size() > i) ? ev_at[i] : -1;
  endfunction
  function automatic logic [31:0] who_of(input int i);
    return (ev_who.size() > i) ? 32'(ev_who[i]) : 32'hFF;
  endfunction
  function automatic logic [31:0] data_of(input int i);
    return (ev_data.size() > i) ? 32'(ev_data[i]) : 32'hDEAD_0000;
  endfunction

  typedef struct {
    bit          wr, rd0, rd1;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    req_idx_t    exp_who;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic run_table();
    vecs[0] = '{1, 0, 0, 20'h30, 16'h1234, REQ_WR,  16'h0000};
    vecs[1] = '{0, 0, 1, 20'h30, 16'h0000, REQ_RD1, 16'h1234};
    vecs[2] = '{0, 1, 0, 20'h31, 16'h0000, REQ_RD0, dflt(8'h31)};
    vecs[3] = '{1, 0, 1, 20'h32, 16'hBEEF, REQ_WR,  16'h0000};
    vecs[4] = '{0, 1, 0, 20'h32, 16'h0000, REQ_RD0, 16'hBEEF};
    vecs[5] = '{1, 1, 1, 20'h33, 16'h0F0F, REQ_WR,  16'h0000};
    vecs[6] = '{0, 0, 1, 20'h33, 16'h0000, REQ_RD1, 16'h0F0F};
    vecs[7] = '{1, 0, 0, 20'hFF, 16'hFFFF, REQ_WR,  16'h0000};
    for (int i = 0; i < 8; i++) begin
      bit got = 0;
      int at = -1;
      req_idx_t who = REQ_WR;
      logic [DW-1:0] data = '0;
      logic [2:0] pulses = '0;
      apply_stimulus(vecs[i].wr, vecs[i].rd0, vecs[i].rd1, vecs[i].addr, vecs[i].wdata);
      for (int c = 1; c <= 20 && !got; c++) begin
        @(negedge clk);
        if (wr_ack || rd0_valid || rd1_valid) begin
          got = 1; at = c;
          pulses = {wr_ack, rd0_valid, rd1_valid};
          who  = wr_ack ? REQ_WR : (rd0_valid ? REQ_RD0 : REQ_RD1);
          data = rd0_valid ? rd0_data : rd1_data;
          apply_stimulus(0, 0, 0, vecs[i].addr, '0);
        end
      end
      check_output($sformatf("vec%0d_seen", i), 32'(got), 1);
      check_output($sformatf("vec%0d_onehot", i), 32'($countones(pulses)), 1);
      check_output($sformatf("vec%0d_who", i), 32'(who), 32'(vecs[i].exp_who));
      check_output($sformatf("vec%0d_latency", i), 32'(at), ACC + 1);
      if (vecs[i].exp_who != REQ_WR)
        check_output($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      @(negedge clk);
      check_output($sformatf("vec%0d_idle", i), 32'(busy), 0);
      check_output($sformatf("vec%0d_addr_hold", i), 32'(sram_addr), 32'(vecs[i].addr));
    end
  endtask

  task automatic run_sequences();
    // Single write then single read of the same word.
    do_reset();
    apply_stimulus(1, 0, 0, 20'h00010, 16'hA5A4);
    watch(5, 0);
    check_output("wr_we_low_cycles", we_cnt, 2);
    check_output("wr_dq_oe_cycles", dqoe_cnt, 3);
    check_output("wr_pulse_count", ev_at.size(), 1);
    check_output("wr_ack_cycle", at_of(0), 3);
    check_output("wr_sram_word", 32'(sram_mem[8'h10]), 32'hA5A4);

    apply_stimulus(0, 1, 0, 20'h00010, '0);
    watch(5, 0);
    check_output("rd_oe_low_cycles", oe_cnt, 2);
    check_output("rd_dq_oe_cycles", dqoe_cnt, 0);
    check_output("rd_pulse_count", ev_at.size(), 1);
    check_output("rd_who", who_of(0), 32'(REQ_RD0));
    check_output("rd_valid_cycle", at_of(0), 3);
    check_output("rd_data", data_of(0), 32'hA5A4);
    check_output("rd_data_held", 32'(rd0_data), 32'hA5A4);

    // Write preempts simultaneous reads.
    do_reset();
    apply_stimulus(1, 1, 1, 20'h00010, 16'h0101);
    watch(13, 0);
    check_output("pre_pulse_count", ev_at.size(), 3);
    check_output("pre_first", who_of(0), 32'(REQ_WR));
    check_output("pre_second", who_of(1), 32'(REQ_RD0));
    check_output("pre_third", who_of(2), 32'(REQ_RD1));
    check_output("pre_at0", at_of(0), 3);
    check_output("pre_at1", at_of(1), 7);
    check_output("pre_at2", at_of(2), 11);
    check_output("pre_rd0_data", data_of(1), 32'h0101);
    check_output("pre_rd1_data", data_of(2), 32'h0101);

    // Both read ports held through four accesses.
    do_reset();
    apply_stimulus(0, 1, 1, 20'h00011, '0);
    watch(16, 1);
    apply_stimulus(0, 0, 0, 20'h00011, '0);
    check_output("rr_pulse_count", ev_at.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      check_output($sformatf("rr_order%0d", i), who_of(i), (i % 2 == 0) ? 32'(REQ_RD0) : 32'(REQ_RD1));
`else
      check_output($sformatf("rr_order%0d", i), who_of(i), 32'(REQ_RD0));
`endif
      check_output($sformatf("rr_at%0d", i), at_of(i), 3 + 4 * i);
    end
    repeat (4) @(negedge clk);

    // Request dropped right after it was latched still completes.
    apply_stimulus(0, 0, 1, 20'h00010, '0);
    @(negedge clk);
    rd1_req = 0;
    watch(4, 0);
    check_output("drop_pulse_count", ev_at.size(), 1);
    check_output("drop_who", who_of(0), 32'(REQ_RD1));
    check_output("drop_at", at_of(0), 2);
    check_output("drop_data", data_of(0), 32'h0101);

    // Reset during the first ACCESS cycle of a write.
    apply_stimulus(1, 0, 0, 20'h00020, 16'hDEAD);
    @(negedge clk);
    check_output("abort_we_before", 32'(we_n), 0);
    rst = 1'b1;
    #1;
    check_output("abort_we_n", 32'(we_n), 1);
    check_output("abort_dq_oe", 32'(dq_oe), 0);
    check_output("abort_busy", 32'(busy), 0);
    check_output("abort_ce_n", 32'(ce_n), 1);
    check_output("abort_ack", 32'(wr_ack), 0);
    wr_req = 0;
    @(negedge clk);
    rst = 1'b0;
    watch(6, 0);
    check_output("abort_no_pulse", ev_at.size(), 0);
    check_output("abort_not_written", 32'(written[8'h20]), 0);
    apply_stimulus(0, 1, 0, 20'h00010, '0);
    watch(5, 0);
    check_output("abort_rd_who", who_of(0), 32'(REQ_RD0));
    check_output("abort_rd_data", data_of(0), 32'h0101);
  endtask

  task automatic run_fast_reads();
    int hits[$];
    b_rd1_addr = 20'h00040;
    b_rd1_req  = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (b_rd1_valid) begin
        check_output($sformatf("fast_data%0d", hits.size()), 32'(b_rd1_data),
                     32'(b_rd1_addr[15:0] ^ 16'h5A5A));
        hits.push_back(i);
        b_rd1_addr = b_rd1_addr + 20'd1;
      end
    end
    b_rd1_req = 0;
    check_output("fast_pulse_count", hits.size(), 4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("fast_at%0d", i), (hits.size() > i) ? hits[i] : -1, 2 + 3 * i);
  endtask

  // Random traffic against a transaction-level model: each grant at edge e
  // produces a pulse visible after edge e+ACC and frees the arbiter at e+ACC+2.
  task automatic run_random(input int cycles);
    logic [15:0] rm [0:15];
    int free_at = 0, pulse_edge = -100, pwho = 0;
    logic [15:0] pdata = '0, last0 = '0, last1 = '0;
    bit ptr = 0;
    for (int i = 0; i < 16; i++) rm[i] = dflt(8'(i));
    do_reset();
    for (int e = 0; e < cycles; e++) begin
      @(posedge clk);
      if (e >= free_at && (wr_req || rd0_req || rd1_req)) begin
        if (wr_req) pwho = 0;
        else if (rd0_req && rd1_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          pwho = ptr ? 2 : 1;
`else
          pwho = 1;
`endif
        end
        else pwho = rd0_req ? 1 : 2;
        if (pwho != 0) ptr = (pwho == 1);
        if (pwho == 0) rm[wr_addr[3:0]] = wr_data;
        else pdata = rm[(pwho == 1) ? rd0_addr[3:0] : rd1_addr[3:0]];
        pulse_edge = e + ACC;
        free_at    = e + ACC + 2;
      end
      @(negedge clk);
      if (e == pulse_edge && pwho == 1) last0 = pdata;
      if (e == pulse_edge && pwho == 2) last1 = pdata;
      check_output("rnd_busy", 32'(busy), 32'(e < free_at - 1));
      check_output("rnd_wr_ack", 32'(wr_ack), 32'(e == pulse_edge && pwho == 0));
      check_output("rnd_rd0_valid", 32'(rd0_valid), 32'(e == pulse_edge && pwho == 1));
      check_output("rnd_rd1_valid", 32'(rd1_valid), 32'(e == pulse_edge && pwho == 2));
      check_output("rnd_rd0_data", 32'(rd0_data), 32'(last0));
      check_output("rnd_rd1_data", 32'(rd1_data), 32'(last1));
      if (e == pulse_edge && pwho == 0) begin
        if ($urandom_range(1) == 0) wr_req = 0;
        else begin wr_addr = 20'($urandom_range(15)); wr_data = 16'($urandom); end
      end else if (!wr_req && $urandom_range(5) == 0) begin
        wr_req = 1; wr_addr = 20'($urandom_range(15)); wr_data = 16'($urandom);
      end
      if (e == pulse_edge && pwho == 1) begin
        if ($urandom_range(1) == 0) rd0_req = 0;
        else rd0_addr = 20'($urandom_range(15));
      end else if (!rd0_req && $urandom_range(2) == 0) begin
        rd0_req = 1; rd0_addr = 20'($urandom_range(15));
      end
      if (e == pulse_edge && pwho == 2) begin
        if ($urandom_range(1) == 0) rd1_req = 0;
        else rd1_addr = 20'($urandom_range(15));
      end else if (!rd1_req && $urandom_range(2) == 0) begin
        rd1_req = 1; rd1_addr = 20'($urandom_range(15));
      end
    end
    apply_stimulus(0, 0, 0, '0, '0);
  endtask

  initial begin
    do_reset();
    run_table();
    run_sequences();
    run_fast_reads();
    run_random(1500);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: bench did not finish, got %0d passes of %0d checks", passes, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
